branch_div_ctrl: RTL and testbench
==================================

Name: branch_div_ctrl

Overview:
- Divergence controller for one SM core; sits between the instruction decoder and the predicate mask stack.
- Turns decoded IF / ELSE / ENDIF control instructions into single-cycle push / comp / pop strobes on the mask stack.
- Reads back the stack's all_false flag and tells the fetch unit to jump over a branch body that no lane executes.
- Keeps its own depth counter, so stack overflow and underflow are flagged and never reach the stack.

Parameters:
- N_CORES, 4: lanes per SM; width of the condition and mask vectors.
- STACK_DEPTH, 3: log2 of mask-stack locations. Maximum nesting depth is (1<<STACK_DEPTH)-1 = 7.
- PC_W, 8: width of the program counter and branch targets.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decoder presents a control instruction.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr_op  in  2  00=IF, 01=ELSE, 10=ENDIF, 11=reserved.
- instr_cond  in  N_CORES  per-lane branch predicate (IF only).
- else_pc  in  PC_W  IF target when every lane is false.
- endif_pc  in  PC_W  ELSE target when every lane is false.
- ps_push  out  1  one-cycle push strobe to the stack.
- ps_pop  out  1  one-cycle pop strobe to the stack.
- ps_comp  out  1  one-cycle complement strobe to the stack.
- ps_d_in  out  N_CORES  push data, equal to latched cond & ps_tos.
- ps_tos  in  N_CORES  stack top-of-stack.
- ps_all_false  in  1  stack flag; combinational from the stack pointer.
- done  out  1  one-cycle completion pulse.
- redirect  out  1  with done: fetch must jump to target_pc.
- target_pc  out  PC_W  jump target; valid when redirect=1.
- err  out  1  with done: overflow, underflow or reserved op; no stack strobe was issued.
- depth  out  STACK_DEPTH  current nesting depth.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, depth=0.
  - ps_push, ps_pop, ps_comp, done, redirect, err all 0; ps_d_in=0; target_pc=0.
  - instr_ready=1 once reset is released.
- Reset asserted mid-operation aborts immediately. No strobe is completed afterwards and no done pulse is produced.
- Accept: on a clock edge with instr_valid & instr_ready, latch op, cond, else_pc and endif_pc. instr_ready drops on the next cycle.
- Exactly one stack strobe is issued per instruction, and it is high for exactly one cycle.
- States: IDLE, PUSH, COMP, POP, SETTLE, RESP.
- IDLE → next state on accept:
  - IF with depth == 7 → RESP with err=1.
  - IF otherwise → PUSH.
  - ELSE with depth == 0 → RESP with err=1.
  - ELSE otherwise → COMP.
  - ENDIF with depth == 0 → RESP with err=1.
  - ENDIF otherwise → POP.
  - op 11 → RESP with err=1.
- PUSH: ps_push=1 and ps_d_in = cond & ps_tos, with ps_tos sampled at accept. depth increments at the end of the cycle. → SETTLE.
- COMP: ps_comp=1. depth unchanged. → SETTLE.
- POP: ps_pop=1. depth decrements. → RESP with redirect=0.
- SETTLE: the stack has updated, so ps_all_false reflects the new top. Sample it at the end of the cycle:
  - IF and all_false → redirect=1, target_pc=else_pc.
  - ELSE and all_false → redirect=1, target_pc=endif_pc.
  - otherwise → redirect=0.
  - → RESP.
- RESP: done=1 for one cycle, with redirect / target_pc / err as determined. → IDLE.
- Latency from the accept edge to the done cycle:
  - IF and ELSE: done in the 3rd cycle after accept.
  - ENDIF: done in the 2nd cycle.
  - Error cases: done in the 1st cycle.
- instr_valid is ignored outside IDLE. Back-to-back instructions: the next accept happens the cycle after RESP.
- depth never wraps: increments are blocked at 7 and decrements at 0.
- target_pc holds its last value when redirect=0.

Test Plan:
- Reset, then IF with cond=4'b1010, ps_tos=4'b1111 → ps_push pulse with ps_d_in=1010; done 3 cycles after accept with redirect=0; depth=1.
- IF with cond=0000, else_pc=8'h40 → ps_all_false=1 in SETTLE; done with redirect=1, target_pc=8'h40.
- IF(1010), ELSE → ps_comp pulse; top becomes 0101, not all false; done with redirect=0. Then ENDIF → ps_pop pulse, done 2 cycles after accept, depth back to 0.
- ENDIF at depth 0, and op=11 → done with err=1 the cycle after accept; no ps_* strobe; depth stays 0.
- Eight nested IFs with cond=1111 → first seven push (depth=7); eighth returns err=1 with no ps_push.
- Assert reset during SETTLE of an IF → all outputs 0 immediately, depth=0, no done pulse; instr_ready=1 after release.

Source files
------------

// File: rtl/branch_div_ctrl.sv
// Divergence controller: turns IF/ELSE/ENDIF into single-cycle mask-stack
// strobes, tracks nesting depth and requests a fetch jump over dead bodies.
module branch_div_ctrl #(
    parameter int N_CORES     = 4,
    parameter int STACK_DEPTH = 3,
    parameter int PC_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [1:0]             instr_op,
    input  logic [N_CORES-1:0]     instr_cond,
    input  logic [PC_W-1:0]        else_pc,
    input  logic [PC_W-1:0]        endif_pc,
    output logic                   ps_push,
    output logic                   ps_pop,
    output logic                   ps_comp,
    output logic [N_CORES-1:0]     ps_d_in,
    input  logic [N_CORES-1:0]     ps_tos,
    input  logic                   ps_all_false,
    output logic                   done,
    output logic                   redirect,
    output logic [PC_W-1:0]        target_pc,
    output logic                   err,
    output logic [STACK_DEPTH-1:0] depth
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_COMP,
        S_POP,
        S_SETTLE,
        S_RESP
    } state_e;

    localparam logic [1:0] OP_IF    = 2'b00;
    localparam logic [1:0] OP_ELSE  = 2'b01;
    localparam logic [1:0] OP_ENDIF = 2'b10;

    localparam logic [STACK_DEPTH-1:0] D_MAX  = '1;
    localparam logic [STACK_DEPTH-1:0] D_ZERO = '0;

    state_e                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [PC_W-1:0]          else_q, else_d;
    logic [PC_W-1:0]          endif_q, endif_d;
    logic [N_CORES-1:0]       din_q, din_d;
    logic [PC_W-1:0]          tgt_q, tgt_d;
    logic [STACK_DEPTH-1:0]   depth_q, depth_d;
    logic                     redir_q, redir_d;
    logic                     err_q, err_d;
    logic                     ready_q, push_q, pop_q, comp_q, done_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        else_d  = else_q;
        endif_d = endif_q;
        din_d   = din_q;
        tgt_d   = tgt_q;
        depth_d = depth_q;
        redir_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    else_d  = else_pc;
                    endif_d = endif_pc;
                    case (instr_op)
                        OP_IF: begin
                            if (depth_q == D_MAX) begin
                                state_d = S_RESP;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_PUSH;
                                din_d   = instr_cond & ps_tos;
                            end
                        end
                        OP_ELSE: begin
                            if (depth_q == D_ZERO) begin
                                state_d = S_RESP;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_COMP;
                            end
                        end
                        OP_ENDIF: begin
                            if (depth_q == D_ZERO) begin
                                state_d = S_RESP;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_POP;
                            end
                        end
                        default: begin
                            state_d = S_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_PUSH: begin
                if (depth_q != D_MAX) depth_d = depth_q + 1'b1;
                state_d = S_SETTLE;
            end
            S_COMP: begin
                state_d = S_SETTLE;
            end
            S_POP: begin
                if (depth_q != D_ZERO) depth_d = depth_q - 1'b1;
                state_d = S_RESP;
            end
            S_SETTLE: begin
                // Stack has taken the strobe; all_false now describes the new top
                if (ps_all_false && op_q != OP_ENDIF) begin
                    redir_d = 1'b1;
                    tgt_d   = (op_q == OP_IF) ? else_q : endif_q;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            else_q  <= '0;
            endif_q <= '0;
            din_q   <= '0;
            tgt_q   <= '0;
            depth_q <= '0;
            redir_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            comp_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            else_q  <= else_d;
            endif_q <= endif_d;
            din_q   <= din_d;
            tgt_q   <= tgt_d;
            depth_q <= depth_d;
            redir_q <= redir_d;
            err_q   <= err_d;
            ready_q <= (state_d == S_IDLE);
            push_q  <= (state_d == S_PUSH);
            pop_q   <= (state_d == S_POP);
            comp_q  <= (state_d == S_COMP);
            done_q  <= (state_d == S_RESP);
        end
    end

    assign instr_ready = ready_q;
    assign ps_push     = push_q;
    assign ps_pop      = pop_q;
    assign ps_comp     = comp_q;
    assign ps_d_in     = din_q;
    assign done        = done_q;
    assign redirect    = redir_q;
    assign target_pc   = tgt_q;
    assign err         = err_q;
    assign depth       = depth_q;

endmodule

// File: tb/tb_branch_div_ctrl.sv
// Bench for branch_div_ctrl: behavioural mask stack, per-instruction
// reference model and a per-cycle compare process.
module tb_branch_div_ctrl;

    localparam int N  = 4;
    localparam int SD = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [1:0]    instr_op = 2'b00;
    logic [N-1:0]  instr_cond = '0;
    logic [PW-1:0] else_pc = '0;
    logic [PW-1:0] endif_pc = '0;
    logic          ps_push, ps_pop, ps_comp;
    logic [N-1:0]  ps_d_in;
    logic [N-1:0]  ps_tos;
    logic          ps_all_false;
    logic          done, redirect, err;
    logic [PW-1:0] target_pc;
    logic [SD-1:0] depth;

    always #5 clk = ~clk;

    branch_div_ctrl #(.N_CORES(N), .STACK_DEPTH(SD), .PC_W(PW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_cond(instr_cond),
        .else_pc(else_pc), .endif_pc(endif_pc),
        .ps_push(ps_push), .ps_pop(ps_pop), .ps_comp(ps_comp),
        .ps_d_in(ps_d_in), .ps_tos(ps_tos), .ps_all_false(ps_all_false),
        .done(done), .redirect(redirect), .target_pc(target_pc),
        .err(err), .depth(depth)
    );

    // Environment: predicate mask stack reacting to the DUT strobes
    logic [N-1:0] estk [0:7];
    logic [2:0]   esp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            esp      <= 3'd0;
            estk[0]  <= '1;
        end else if (ps_push) begin
            estk[esp + 3'd1] <= ps_d_in;
            esp              <= esp + 3'd1;
        end else if (ps_comp) begin
            estk[esp] <= ~estk[esp] & estk[esp - 3'd1];
        end else if (ps_pop) begin
            esp <= esp - 3'd1;
        end
    end

    assign ps_tos       = estk[esp];
    assign ps_all_false = (estk[esp] == '0);

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [N-1:0]  mstk [0:7];
    int            mdep = 0;
    logic [PW-1:0] mtgt = '0;
    bit            active = 1'b0;
    bit            chk_en = 1'b0;
    int            since = 0;
    int            lat = 0;
    int            olddep = 0;
    int            newdep = 0;
    bit            e_push, e_pop, e_comp, e_redir, e_err;
    logic [N-1:0]  e_din;
    logic [PW-1:0] e_tgt;
    logic [N-1:0]  last_din = '0;
    bit            last_redir = 1'b0;
    bit            last_err = 1'b0;
    int            last_lat = 0;

    task automatic model_accept(input logic [1:0] op, input logic [N-1:0] cond,
                                input logic [PW-1:0] ep,
                                input logic [PW-1:0] enp);
        olddep  = mdep;
        e_push  = 0; e_pop = 0; e_comp = 0;
        e_redir = 0; e_err = 0;
        e_din   = '0;
        e_tgt   = '0;
        lat     = 1;
        case (op)
            2'd0: begin
                if (mdep == 7) e_err = 1;
                else begin
                    e_push = 1;
                    e_din  = cond & mstk[mdep];
                    mdep++;
                    mstk[mdep] = e_din;
                    lat = 3;
                    if (e_din == '0) begin e_redir = 1; e_tgt = ep; end
                end
            end
            2'd1: begin
                if (mdep == 0) e_err = 1;
                else begin
                    e_comp = 1;
                    mstk[mdep] = ~mstk[mdep] & mstk[mdep-1];
                    lat = 3;
                    if (mstk[mdep] == '0) begin e_redir = 1; e_tgt = enp; end
                end
            end
            2'd2: begin
                if (mdep == 0) e_err = 1;
                else begin
                    e_pop = 1;
                    mdep--;
                    lat = 2;
                end
            end
            default: e_err = 1;
        endcase
        newdep = mdep;
        since  = 0;
        active = 1;
    endtask

    always @(negedge clk) begin : compare
        logic [6:0] ev;
        int ed;
        if (chk_en) begin
            if (active) begin
                since++;
                ev = {1'b0, e_push && since == 1, e_pop && since == 1,
                      e_comp && since == 1, since == lat,
                      e_redir && since == lat, e_err && since == lat};
                ed = (since >= 2) ? newdep : olddep;
            end else begin
                ev = 7'b1000000;
                ed = mdep;
            end
            check("ctl", {instr_ready, ps_push, ps_pop, ps_comp, done,
                          redirect, err}, ev);
            check("depth", depth, ed);
            if (active && since == 1 && e_push) begin
                check("d_in", ps_d_in, e_din);
                last_din = ps_d_in;
            end
            if (active && since == lat) begin
                if (e_redir) mtgt = e_tgt;
                last_redir = redirect;
                last_err   = err;
                last_lat   = done ? since : 0;
                active     = 0;
            end
            check("target", target_pc, mtgt);
        end
    end

    // Caller sits just after a negedge; returns just after a negedge
    task automatic issue(input logic [1:0] op, input logic [N-1:0] cond,
                         input logic [PW-1:0] ep, input logic [PW-1:0] enp,
                         input bit wait_done);
        for (int n = 0; n < 50 && !instr_ready; n++) begin
            instr_valid = 1'b0;
            @(negedge clk);
        end
        if (!instr_ready) check("ready_timeout", 0, 1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_cond  = cond;
        else_pc     = ep;
        endif_pc    = enp;
        @(posedge clk);
        model_accept(op, cond, ep, enp);
        @(negedge clk);
        instr_valid = 1'b0;
        if (wait_done) begin
            for (int n = 0; n < 50 && !instr_ready; n++) begin
                // valid must be ignored while busy
                instr_valid = 1'($urandom_range(0, 1));
                instr_op    = 2'($urandom_range(0, 3));
                instr_cond  = 4'($urandom_range(0, 15));
                @(negedge clk);
            end
            instr_valid = 1'b0;
            if (!instr_ready) check("done_timeout", 0, 1);
        end
    endtask

    initial begin
        mstk[0] = '1;
        repeat (3) @(negedge clk);
        check("rst_outs", {ps_push, ps_pop, ps_comp, done, redirect, err}, 0);
        check("rst_din", ps_d_in, 0);
        check("rst_tgt", target_pc, 0);
        check("rst_depth", depth, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("ready_after_reset", instr_ready, 1);

        issue(2'd0, 4'b1010, 8'h11, 8'h22, 1);
        check("if1_din", last_din, 4'b1010);
        check("if1_redir", last_redir, 0);
        check("if1_lat", last_lat, 3);
        check("if1_depth", depth, 1);

        issue(2'd0, 4'b0000, 8'h40, 8'h55, 1);
        check("if0_redir", last_redir, 1);
        check("if0_tgt", target_pc, 8'h40);
        check("if0_depth", depth, 2);

        issue(2'd2, '0, '0, '0, 1);
        issue(2'd2, '0, '0, '0, 1);
        check("pop2_depth", depth, 0);
        check("pop_lat", last_lat, 2);

        issue(2'd0, 4'b1010, 8'h12, 8'h23, 1);
        issue(2'd1, 4'b0000, 8'h33, 8'h66, 1);
        check("else_redir", last_redir, 0);
        check("else_lat", last_lat, 3);
        check("else_tgt_hold", target_pc, 8'h40);
        issue(2'd2, '0, '0, '0, 1);
        check("endif_depth", depth, 0);

        issue(2'd0, 4'b1111, 8'h13, 8'h24, 1);
        issue(2'd1, 4'b0000, 8'h34, 8'h77, 1);
        check("else_af_redir", last_redir, 1);
        check("else_af_tgt", target_pc, 8'h77);
        issue(2'd2, '0, '0, '0, 1);

        issue(2'd2, '0, '0, '0, 1);
        check("uf_err", last_err, 1);
        check("uf_lat", last_lat, 1);
        check("uf_depth", depth, 0);
        issue(2'd3, '0, '0, '0, 1);
        check("rsv_err", last_err, 1);
        check("rsv_lat", last_lat, 1);

        for (int i = 0; i < 7; i++) issue(2'd0, 4'b1111, 8'h50, 8'h60, 1);
        check("nest_depth", depth, 7);
        issue(2'd0, 4'b1111, 8'h50, 8'h60, 1);
        check("ovf_err", last_err, 1);
        check("ovf_depth", depth, 7);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            logic [N-1:0] c;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            c  = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom_range(0, 15));
            issue(op, c, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 8 && mdep > 0; i++) issue(2'd2, '0, '0, '0, 1);
        check("drain_depth", depth, 0);

        issue(2'd0, 4'b1100, 8'h99, 8'h98, 0);
        @(negedge clk);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("abort_outs", {ps_push, ps_pop, ps_comp, done, redirect, err}, 0);
        check("abort_depth", depth, 0);
        check("abort_tgt", target_pc, 0);
        active = 0;
        mdep   = 0;
        mtgt   = '0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_abort", instr_ready, 1);
        chk_en = 1'b1;
        issue(2'd0, 4'b0110, 8'h21, 8'h31, 1);
        check("post_abort_depth", depth, 1);
        check("post_abort_din", last_din, 4'b0110);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
